multilane_preview_fifo: RTL
===========================

// Module: multilane_preview_fifo
//
// PURPOSE
//  Show-ahead FIFO that accepts 0..LANES words and releases 0..LANES words per clock.
//  It generalises the two-word preview FIFO to any lane count, so a consumer can inspect
//  the next LANES words before committing to consume them.
//  Storage is a single register-based circular buffer, with no vendor FIFO primitives.
//  It sits between variable-rate parsers and packers in the datapath.
//
// PARAMETERS
//  WIDTH   32                 data word width, >=1
//  DEPTH   16                 capacity in words; power of two, >= 2*LANES
//  LANES   2                  max words written/read per cycle, >=1
//  CNT_W   $clog2(LANES+1)    width of wrcnt/rdcnt (derived, do not override)
//  USED_W  $clog2(DEPTH)      pointer width (derived, do not override)
//
// PORTS
//  clk       in   1             single clock, rising edge
//  nrst      in   1             asynchronous active-low reset
//  wrcnt     in   CNT_W         number of words to write this cycle (0..LANES)
//  id        in   LANES*WIDTH   write lanes; lane k = id[k*WIDTH +: WIDTH], lane 0 oldest
//  rdcnt     in   CNT_W         number of words to consume this cycle (0..LANES)
//  od        out  LANES*WIDTH   preview lanes; lane k = word at head+k
//  od_valid  out  LANES         thermometer; od_valid[k] = (usedw > k)
//  usedw     out  USED_W+1      words stored, 0..DEPTH
//  free      out  USED_W+1      DEPTH - usedw
//  empty     out  1             usedw == 0
//  full      out  1             usedw == DEPTH
//  wr_err    out  1             registered 1-cycle pulse: write request rejected
//  rd_err    out  1             registered 1-cycle pulse: read request rejected
//
// BEHAVIOUR
//  - Reset (nrst=0, async): wr_ptr=rd_ptr=0, usedw=0, free=DEPTH, empty=1, full=0,
//    od_valid=0, od=0, wr_err=rd_err=0. Memory contents are not cleared.
//    Reset mid-operation discards all stored words immediately.
//  - Read acceptance: rd_acc = (rdcnt<=LANES && rdcnt<=usedw) ? rdcnt : 0.
//    The request is all-or-nothing; there are no partial reads.
//  - Write acceptance: wr_acc = (wrcnt<=LANES && wrcnt<=free+rd_acc) ? wrcnt : 0.
//    A same-cycle accepted read frees space for the write, so read+write while full is legal.
//  - Rejection: if rdcnt!=0 and rd_acc==0, rd_err=1 on the next cycle. If wrcnt!=0 and
//    wr_acc==0, wr_err=1 on the next cycle. A rejected request leaves pointers and data untouched.
//    Any count > LANES is rejected.
//  - Update at clock edge:
//      write lane k (k<wr_acc) goes to mem[wr_ptr+k mod DEPTH]
//      wr_ptr += wr_acc; rd_ptr += rd_acc (mod DEPTH, natural wrap)
//      usedw  += wr_acc - rd_acc
//  - Preview lanes: od lane k = mem[rd_ptr+k mod DEPTH] when od_valid[k], otherwise 0.
//    od and od_valid are combinational from registered state only (no comb path from
//    wrcnt/rdcnt/id).
//  - Latency: a word written at edge t is visible on od after edge t. There is no bypass:
//    an empty FIFO reads nothing in the cycle it is written, because rd_acc uses the pre-edge usedw.
//  - Flags free, empty and full derive from registered usedw and are glitch-free after the edge.
//  - Order: FIFO order is preserved across lanes and wrap. Lane 0 of a write follows the
//    last lane of the previous write.
//
// TESTING
//  1 Reset -> usedw=0, empty=1, od_valid=0. Write wrcnt=2 id={B,A} -> next cycle od lane0=A,
//    lane1=B, od_valid=2'b11, usedw=2.
//  2 LANES=2, DEPTH=16: single-word writes of 0..15 fill the FIFO -> full=1, free=0.
//    Then a wrcnt=1 write -> wr_err pulse, usedw stays 16.
//  3 Full FIFO, same cycle rdcnt=2 and wrcnt=2 -> both accepted, usedw=16, no errors,
//    od lane0/1 advance by two.
//  4 usedw=1, rdcnt=2 -> rd_err pulse, usedw=1, od lane0 unchanged. Then rdcnt=1 -> empty=1.
//  5 Wrap: 20 cycles of mixed wrcnt/rdcnt in {0,1,2} crossing ptr wrap -> od stream equals a
//    scoreboard queue, usedw matches the model every cycle.
//  6 Assert nrst mid-stream with usedw=7 -> flags reset asynchronously within the same cycle.
//    After release, a write of X -> od lane0=X.

Source files
------------

// File: rtl/multilane_preview_fifo.sv
// multilane_preview_fifo
//   Show-ahead FIFO built on a register circular buffer. Each clock it accepts 0..LANES
//   words and releases 0..LANES words. The next LANES stored words are always presented on
//   the preview lanes, so a consumer can inspect them before it commits to a read.
//
// Ports
//   clk       rising-edge clock
//   nrst      asynchronous active-low reset
//   wrcnt     words to write this cycle (0..LANES); id lane k = id[k*WIDTH +: WIDTH], lane 0 oldest
//   rdcnt     words to consume this cycle (0..LANES)
//   od        preview lanes; lane k = word at head+k, zero when not valid
//   od_valid  thermometer of valid preview lanes
//   usedw     words stored (0..DEPTH); free = DEPTH - usedw
//   empty     usedw == 0;  full  usedw == DEPTH
//   wr_err    registered one-cycle pulse: the previous write request was rejected
//   rd_err    registered one-cycle pulse: the previous read request was rejected
module multilane_preview_fifo #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned CNT_W  = $clog2(LANES + 1),
  parameter int unsigned USED_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [CNT_W-1:0]       wrcnt,
  input  logic [LANES*WIDTH-1:0] id,
  input  logic [CNT_W-1:0]       rdcnt,
  output logic [LANES*WIDTH-1:0] od,
  output logic [LANES-1:0]       od_valid,
  output logic [USED_W:0]        usedw,
  output logic [USED_W:0]        free,
  output logic                   empty,
  output logic                   full,
  output logic                   wr_err,
  output logic                   rd_err
);

  localparam int unsigned UW    = USED_W + 1;
  // Wide enough for free + rd_acc (at most DEPTH + LANES <= 2*DEPTH).
  localparam int unsigned SUM_W = USED_W + 2;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [USED_W-1:0] r_wr_ptr;
  logic [USED_W-1:0] r_rd_ptr;
  logic [UW-1:0]     r_usedw;
  logic              r_wr_err;
  logic              r_rd_err;

  logic [SUM_W-1:0]  w_used_ext;
  logic [SUM_W-1:0]  w_free_ext;
  logic [SUM_W-1:0]  w_lanes_ext;
  logic [SUM_W-1:0]  w_rdcnt_ext;
  logic [SUM_W-1:0]  w_wrcnt_ext;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [CNT_W-1:0]  w_rd_acc;
  logic [CNT_W-1:0]  w_wr_acc;

  // Acceptance uses only pre-edge state, so a word written this cycle cannot be read this cycle.
  always_comb begin
    w_used_ext  = SUM_W'(r_usedw);
    w_free_ext  = SUM_W'(DEPTH) - w_used_ext;
    w_lanes_ext = SUM_W'(LANES);
    w_rdcnt_ext = SUM_W'(rdcnt);
    w_wrcnt_ext = SUM_W'(wrcnt);
    w_rd_ok     = (w_rdcnt_ext <= w_lanes_ext) && (w_rdcnt_ext <= w_used_ext);
    w_rd_acc    = w_rd_ok ? rdcnt : '0;
    // An accepted read frees its slots for a same-cycle write.
    w_wr_ok     = (w_wrcnt_ext <= w_lanes_ext) &&
                  (w_wrcnt_ext <= w_free_ext + SUM_W'(w_rd_acc));
    w_wr_acc    = w_wr_ok ? wrcnt : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + USED_W'(w_wr_acc);
      r_rd_ptr <= r_rd_ptr + USED_W'(w_rd_acc);
      r_usedw  <= r_usedw + UW'(w_wr_acc) - UW'(w_rd_acc);
      r_wr_err <= (wrcnt != '0) && !w_wr_ok;
      r_rd_err <= (rdcnt != '0) && !w_rd_ok;
    end
  end

  // Storage is not reset; contents are only observable through valid preview lanes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < w_wr_acc) begin
        r_mem[r_wr_ptr + USED_W'(k)] <= id[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    od       = '0;
    od_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      od_valid[k] = r_usedw > UW'(k);
      if (od_valid[k]) begin
        od[k*WIDTH +: WIDTH] = r_mem[r_rd_ptr + USED_W'(k)];
      end
    end
  end

  assign usedw  = r_usedw;
  assign free   = UW'(DEPTH) - r_usedw;
  assign empty  = (r_usedw == '0);
  assign full   = (r_usedw == UW'(DEPTH));
  assign wr_err = r_wr_err;
  assign rd_err = r_rd_err;

endmodule
